pool_compare_reducer: RTL

- Multi-lane streaming max/min reducer for the pooling stage; successor to the single registered two-input min compare.
- Each lane folds a window of consecutive valid samples into one running extreme, then emits the result with a one-cycle valid pulse.
- Sits between the PE output bus and the output buffer writer.
- Mode (max/min), window length and signedness are configurable.

---
 rtl/pool_pkg.sv | 19 +
 rtl/pool_compare_reducer_if.sv | 39 +++
 rtl/pool_compare_lane.sv | 89 ++++++++
 rtl/pool_compare_reducer.sv | 111 +++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Purpose : shared types and helpers for the pooling max/min reducer.
// Latency : n/a (package only).
// Backpr. : n/a. Contents: pool_mode_e (MODE_MAX/MODE_MIN), clamp_window().
package pool_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } pool_mode_e;

  // Window length as used by the reducer: 0 behaves as 1, anything above
  // the supported maximum is cut down to that maximum.
  function automatic int unsigned clamp_window(int unsigned size, int unsigned max_w);
    if (size == 0) return 1;
    if (size > max_w) return max_w;
    return size;
  endfunction

endpackage

// File: rtl/pool_compare_reducer_if.sv
// Purpose : sample/result bundle between PE output bus and the reducer.
// Latency : n/a (wires only).
// Backpr. : none; DATA_IN_VALID is a pure strobe.
// Signals : MODE, WINDOW_SIZE, DATA_IN, DATA_IN_VALID, FLUSH (master->slave);
//           DATA_OUT, DATA_OUT_VALID, BUSY and, with POOL_ARGIDX_EN defined,
//           DATA_OUT_IDX (slave->master).
interface pool_compare_reducer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4,
  parameter int CNT_W      = 5
);
  logic                            MODE;
  logic [CNT_W-1:0]                WINDOW_SIZE;
  logic [NUM_LANES*DATA_WIDTH-1:0] DATA_IN;
  logic                            DATA_IN_VALID;
  logic                            FLUSH;
  logic [NUM_LANES*DATA_WIDTH-1:0] DATA_OUT;
  logic                            DATA_OUT_VALID;
  logic                            BUSY;
`ifdef POOL_ARGIDX_EN
  logic [NUM_LANES*CNT_W-1:0]      DATA_OUT_IDX;
`endif

  modport master (
    output MODE, WINDOW_SIZE, DATA_IN, DATA_IN_VALID, FLUSH,
`ifdef POOL_ARGIDX_EN
    input  DATA_OUT_IDX,
`endif
    input  DATA_OUT, DATA_OUT_VALID, BUSY
  );

  modport slave (
    input  MODE, WINDOW_SIZE, DATA_IN, DATA_IN_VALID, FLUSH,
`ifdef POOL_ARGIDX_EN
    output DATA_OUT_IDX,
`endif
    output DATA_OUT, DATA_OUT_VALID, BUSY
  );
endinterface

// File: rtl/pool_compare_lane.sv
// Purpose : one lane of the reducer: running extreme plus registered result.
// Latency : result register loads on the edge that sees i_emit.
// Backpr. : none; control comes from the top each cycle.
// Ports   : i_clk/i_rst, i_start (first sample), i_upd (later sample),
//           i_mode, i_dat, i_emit -> o_dat; with POOL_ARGIDX_EN also
//           i_pos -> o_idx (winning position in the window).
module pool_compare_lane
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
`ifdef POOL_ARGIDX_EN
  parameter int CNT_W      = 5,
`endif
  parameter int SIGNED_EN  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_upd,
  input  pool_mode_e            i_mode,
  input  logic [DATA_WIDTH-1:0] i_dat,
  input  logic                  i_emit,
`ifdef POOL_ARGIDX_EN
  input  logic [CNT_W-1:0]      i_pos,
  output logic [CNT_W-1:0]      o_idx,
`endif
  output logic [DATA_WIDTH-1:0] o_dat
);

  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  w_gt;
  logic                  w_lt;
  logic                  w_take;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  always_comb begin
    w_gt = 1'b0;
    w_lt = 1'b0;
    if (SIGNED_EN != 0) begin
      w_gt = $signed(i_dat) > $signed(r_acc);
      w_lt = $signed(i_dat) < $signed(r_acc);
    end else begin
      w_gt = i_dat > r_acc;
      w_lt = i_dat < r_acc;
    end
    // Strict compare: on a tie the sample already held stays.
    w_take    = i_upd && ((i_mode == MODE_MAX) ? w_gt : w_lt);
    w_acc_nxt = (i_start || w_take) ? i_dat : r_acc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_out <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      // Result includes the sample arriving in the emitting cycle.
      if (i_emit) r_out <= w_acc_nxt;
    end
  end

  assign o_dat = r_out;

`ifdef POOL_ARGIDX_EN
  logic [CNT_W-1:0] r_idx_acc;
  logic [CNT_W-1:0] r_idx_out;
  logic [CNT_W-1:0] w_idx_nxt;

  always_comb begin
    w_idx_nxt = r_idx_acc;
    if (i_start)     w_idx_nxt = '0;
    else if (w_take) w_idx_nxt = i_pos;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx_acc <= '0;
      r_idx_out <= '0;
    end else begin
      r_idx_acc <= w_idx_nxt;
      if (i_emit) r_idx_out <= w_idx_nxt;
    end
  end

  assign o_idx = r_idx_out;
`endif

endmodule

// File: rtl/pool_compare_reducer.sv
// Purpose : multi-lane streaming max/min window reducer for the pooling stage.
// Latency : 1 cycle from the last (or flushed) sample to DATA_OUT_VALID.
// Backpr. : none; every DATA_IN_VALID sample is consumed.
// Ports   : CLK, RESET (sync, active-high), pool_if (slave modport):
//           MODE/WINDOW_SIZE latched on a window's first sample, DATA_IN +
//           DATA_IN_VALID, FLUSH; DATA_OUT/DATA_OUT_VALID pulse, BUSY.
// Option  : define POOL_ARGIDX_EN to add DATA_OUT_IDX (per-lane argmax/argmin).
module pool_compare_reducer
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4,
  parameter int MAX_WINDOW = 16,
  parameter int SIGNED_EN  = 0,
  parameter int CNT_W      = $clog2(MAX_WINDOW + 1)
) (
  input logic                   CLK,
  input logic                   RESET,
  pool_compare_reducer_if.slave pool_if
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_size;
  pool_mode_e       r_mode;
  logic             r_out_vld;

  logic             w_start;
  logic             w_upd;
  logic [CNT_W-1:0] w_size_clamped;
  logic [CNT_W-1:0] w_size_eff;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_emit;
  logic [CNT_W-1:0] w_count_nxt;

  always_comb begin
    w_start        = pool_if.DATA_IN_VALID && (r_count == '0);
    w_upd          = pool_if.DATA_IN_VALID && (r_count != '0);
    w_size_clamped = CNT_W'(clamp_window(32'(pool_if.WINDOW_SIZE), MAX_WINDOW));
    // The first sample compares against the size it is latching itself,
    // which is what makes size 1 complete in the same cycle.
    w_size_eff     = w_start ? w_size_clamped : r_size;
    w_count_inc    = r_count + ONE;
    w_emit         = (pool_if.DATA_IN_VALID && (w_count_inc == w_size_eff)) ||
                     (pool_if.FLUSH && (pool_if.DATA_IN_VALID || (r_count != '0)));
    w_count_nxt    = r_count;
    if (w_emit)                     w_count_nxt = '0;
    else if (pool_if.DATA_IN_VALID) w_count_nxt = w_count_inc;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count   <= '0;
      r_size    <= '0;
      r_mode    <= MODE_MAX;
      r_out_vld <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_out_vld <= w_emit;
      if (w_start) begin
        r_mode <= pool_mode_e'(pool_if.MODE);
        r_size <= w_size_clamped;
      end
    end
  end

  logic [DATA_WIDTH-1:0] w_lane_dat [NUM_LANES];
`ifdef POOL_ARGIDX_EN
  logic [CNT_W-1:0]      w_lane_idx [NUM_LANES];
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pool_compare_lane #(
      .DATA_WIDTH (DATA_WIDTH),
`ifdef POOL_ARGIDX_EN
      .CNT_W      (CNT_W),
`endif
      .SIGNED_EN  (SIGNED_EN)
    ) u_lane (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_start (w_start),
      .i_upd   (w_upd),
      .i_mode  (r_mode),
      .i_dat   (pool_if.DATA_IN[l*DATA_WIDTH +: DATA_WIDTH]),
      .i_emit  (w_emit),
`ifdef POOL_ARGIDX_EN
      .i_pos   (r_count),
      .o_idx   (w_lane_idx[l]),
`endif
      .o_dat   (w_lane_dat[l])
    );
  end

  always_comb begin
    pool_if.DATA_OUT = '0;
    for (int l = 0; l < NUM_LANES; l++) pool_if.DATA_OUT[l*DATA_WIDTH +: DATA_WIDTH] = w_lane_dat[l];
  end

`ifdef POOL_ARGIDX_EN
  always_comb begin
    pool_if.DATA_OUT_IDX = '0;
    for (int l = 0; l < NUM_LANES; l++) pool_if.DATA_OUT_IDX[l*CNT_W +: CNT_W] = w_lane_idx[l];
  end
`endif

  assign pool_if.DATA_OUT_VALID = r_out_vld;
  assign pool_if.BUSY           = (r_count != '0);

endmodule
